// File: rtl/video_mnist_frame_stats.sv
// video_mnist_frame_stats: AXI4-Stream register slice (s_axi4s_* -> m_axi4s_*) that histograms confident class hits per frame, argmax-scans each snapshot and reports via Wishbone (s_wb_*) and out_irq
module video_mnist_frame_stats #(
  parameter int NUM_CALSS = 11,
  parameter int TUSER_WIDTH = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH = 4,
  parameter int HIST_WIDTH = 20,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter logic INIT_ENABLE = 1'b1,
  parameter logic [TCOUNT_WIDTH-1:0] INIT_COUNT_TH = TCOUNT_WIDTH'(1)
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0] s_axi4s_tcount,
  input  logic s_axi4s_tvalidation,
  input  logic s_axi4s_tvalid,
  output logic s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0] m_axi4s_tcount,
  output logic m_axi4s_tvalidation,
  output logic m_axi4s_tvalid,
  input  logic m_axi4s_tready,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic s_wb_stb_i,
  output logic s_wb_ack_o,
  output logic out_irq
);
  localparam int KW = NUM_CALSS > 1 ? $clog2(NUM_CALSS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic ctl_enable, started;
  logic [TCOUNT_WIDTH-1:0] param_count_th;
  logic [HIST_WIDTH-1:0] acc [NUM_CALSS];
  logic [HIST_WIDTH-1:0] snap [NUM_CALSS];
  logic [HIST_WIDTH-1:0] best_max, result_max;
  logic [KW-1:0] k, best_num, result_number;
  logic [31:0] sum, result_total;
  logic [32:0] sum_nx;
  logic [FRAME_CNT_WIDTH-1:0] frame_count, drop_count;
  logic accept, hit, frame_start, wr;
  assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
  assign accept = s_axi4s_tvalid && s_axi4s_tready;
  assign hit = accept && ctl_enable && s_axi4s_tvalidation && s_axi4s_tcount >= param_count_th
               && 32'(s_axi4s_tnumber) < NUM_CALSS;
  assign frame_start = accept && s_axi4s_tuser[0];
  assign sum_nx = {1'b0, sum} + 33'(snap[k]);
  assign wr = s_wb_stb_i && s_wb_we_i;
  assign s_wb_ack_o = s_wb_stb_i;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser <= '0;
      m_axi4s_tlast <= 1'b0;
      m_axi4s_tnumber <= '0;
      m_axi4s_tcount <= '0;
      m_axi4s_tvalidation <= 1'b0;
    end else if (accept) begin
      m_axi4s_tvalid <= 1'b1;
      m_axi4s_tuser <= s_axi4s_tuser;
      m_axi4s_tlast <= s_axi4s_tlast;
      m_axi4s_tnumber <= s_axi4s_tnumber;
      m_axi4s_tcount <= s_axi4s_tcount;
      m_axi4s_tvalidation <= s_axi4s_tvalidation;
    end else if (m_axi4s_tready) begin
      m_axi4s_tvalid <= 1'b0;
    end
  end
  // a frame-start beat opens the new frame, so its own hit is the first count
  always_ff @(posedge aclk or negedge aresetn) begin
    for (int i = 0; i < NUM_CALSS; i++) begin
      if (!aresetn)
        acc[i] <= '0;
      else if (frame_start)
        acc[i] <= (hit && s_axi4s_tnumber == TNUMBER_WIDTH'(i)) ? HIST_WIDTH'(1) : '0;
      else if (hit && s_axi4s_tnumber == TNUMBER_WIDTH'(i) && acc[i] != '1)
        acc[i] <= acc[i] + 1'b1;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      started <= 1'b0;
      out_irq <= 1'b0;
      k <= '0;
      best_num <= '0;
      best_max <= '0;
      sum <= '0;
      result_number <= '0;
      result_max <= '0;
      result_total <= '0;
      frame_count <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_CALSS; i++) snap[i] <= '0;
    end else begin
      out_irq <= 1'b0;
      if (frame_start) started <= 1'b1;
      if (frame_start && started && state != IDLE) drop_count <= drop_count + 1'b1;
      case (state)
        IDLE: if (frame_start && started) begin
          snap <= acc;
          k <= '0;
          best_num <= '0;
          best_max <= '0;
          sum <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (snap[k] > best_max) begin
            best_max <= snap[k];
            best_num <= k;
          end
          sum <= sum_nx[32] ? '1 : sum_nx[31:0];
          state <= k == KW'(NUM_CALSS - 1) ? DONE : SCAN;
          k <= k + 1'b1;
        end
        DONE: begin
          result_number <= best_num;
          result_max <= best_max;
          result_total <= sum;
          frame_count <= frame_count + 1'b1;
          out_irq <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctl_enable <= INIT_ENABLE;
      param_count_th <= INIT_COUNT_TH;
    end else begin
      if (wr && s_wb_adr_i == WB_ADR_WIDTH'(1) && s_wb_sel_i[0]) ctl_enable <= s_wb_dat_i[0];
      for (int b = 0; b < TCOUNT_WIDTH; b++)
        if (wr && s_wb_adr_i == WB_ADR_WIDTH'(2) && s_wb_sel_i[b/8]) param_count_th[b] <= s_wb_dat_i[b];
    end
  end
  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      WB_ADR_WIDTH'(0): s_wb_dat_o = WB_DAT_WIDTH'(32'h4D53_0001);
      WB_ADR_WIDTH'(1): s_wb_dat_o = WB_DAT_WIDTH'(ctl_enable);
      WB_ADR_WIDTH'(2): s_wb_dat_o = WB_DAT_WIDTH'(param_count_th);
      WB_ADR_WIDTH'(3): s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
      WB_ADR_WIDTH'(4): s_wb_dat_o = WB_DAT_WIDTH'(result_number);
      WB_ADR_WIDTH'(5): s_wb_dat_o = WB_DAT_WIDTH'(result_max);
      WB_ADR_WIDTH'(6): s_wb_dat_o = WB_DAT_WIDTH'(result_total);
      WB_ADR_WIDTH'(7): s_wb_dat_o = WB_DAT_WIDTH'(drop_count);
      default:
        for (int i = 0; i < NUM_CALSS; i++)
          if (s_wb_adr_i == WB_ADR_WIDTH'(16 + i)) s_wb_dat_o = WB_DAT_WIDTH'(snap[i]);
    endcase
  end
endmodule

// File: tb/tb_video_mnist_frame_stats.sv
// tb_video_mnist_frame_stats: randomized and directed check of video_mnist_frame_stats against a frame-level reference model
module tb_video_mnist_frame_stats;
  localparam int N = 11;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [0:0] s_axi4s_tuser = '0, m_axi4s_tuser;
  logic s_axi4s_tlast = 1'b0, m_axi4s_tlast;
  logic [3:0] s_axi4s_tnumber = '0, m_axi4s_tnumber;
  logic [3:0] s_axi4s_tcount = '0, m_axi4s_tcount;
  logic s_axi4s_tvalidation = 1'b0, m_axi4s_tvalidation;
  logic s_axi4s_tvalid = 1'b0, s_axi4s_tready, m_axi4s_tvalid, m_axi4s_tready = 1'b1;
  logic [7:0] s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0, s_wb_dat_o;
  logic s_wb_we_i = 1'b0, s_wb_stb_i = 1'b0, s_wb_ack_o, out_irq;
  logic [3:0] s_wb_sel_i = '0;
  always #5 aclk = ~aclk;
  video_mnist_frame_stats dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast), .s_axi4s_tnumber(s_axi4s_tnumber),
    .s_axi4s_tcount(s_axi4s_tcount), .s_axi4s_tvalidation(s_axi4s_tvalidation),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast), .m_axi4s_tnumber(m_axi4s_tnumber),
    .m_axi4s_tcount(m_axi4s_tcount), .m_axi4s_tvalidation(m_axi4s_tvalidation),
    .m_axi4s_tvalid(m_axi4s_tvalid), .m_axi4s_tready(m_axi4s_tready),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o), .s_wb_we_i(s_wb_we_i),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i), .s_wb_ack_o(s_wb_ack_o), .out_irq(out_irq)
  );
  int passed = 0, total = 0, cyc = 0, irq_seen = 0;
  bit bp = 0, acc_flag;
  int macc[N], msnap[N];
  bit mstarted, men;
  int mth, snap_c, exp_num, exp_max, exp_total, exp_fc, exp_drop;
  logic [10:0] q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic void model_reset();
    foreach (macc[i]) begin macc[i] = 0; msnap[i] = 0; end
    mstarted = 0; men = 1; mth = 1; snap_c = -1000;
    exp_num = 0; exp_max = 0; exp_total = 0; exp_fc = 0; exp_drop = 0; irq_seen = 0;
  endfunction
  function automatic void model_accept(input logic [10:0] b);
    int n = int'(b[8:5]), c = int'(b[4:1]);
    bit hit = men && b[0] && c >= mth && n < N;
    if (b[10]) begin
      if (!mstarted) mstarted = 1;
      else if (cyc - snap_c > 12) begin
        msnap = macc;
        exp_max = 0; exp_total = 0;
        foreach (msnap[i]) begin
          exp_total += msnap[i];
          if (msnap[i] > exp_max) exp_max = msnap[i];
        end
        exp_num = -1;
        foreach (msnap[i]) if (exp_num < 0 && msnap[i] == exp_max) exp_num = i;
        snap_c = cyc;
        exp_fc = (exp_fc + 1) % 65536;
      end else exp_drop = (exp_drop + 1) % 65536;
      foreach (macc[i]) macc[i] = 0;
      if (hit) macc[n] = 1;
    end else if (hit) macc[n]++;
  endfunction
  task automatic tick();
    logic [10:0] b;
    m_axi4s_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (out_irq === 1'b1) irq_seen++;
    chk("irq", 32'(out_irq), 32'(cyc == snap_c + 13));
    if (m_axi4s_tvalid && m_axi4s_tready) begin
      chk("out_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0)
        chk("out_beat", 32'({m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount, m_axi4s_tvalidation}),
            32'(q.pop_front()));
    end
    acc_flag = s_axi4s_tvalid && s_axi4s_tready;
    if (acc_flag) begin
      b = {s_axi4s_tuser[0], s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount, s_axi4s_tvalidation};
      model_accept(b);
      q.push_back(b);
    end
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask
  task automatic send(input bit u, input bit l, input int n, input int c, input bit v);
    s_axi4s_tuser = u; s_axi4s_tlast = l; s_axi4s_tnumber = 4'(n); s_axi4s_tcount = 4'(c);
    s_axi4s_tvalidation = v; s_axi4s_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (acc_flag) break;
    end
    chk("accept_timeout", 32'(acc_flag), 32'd1);
    s_axi4s_tvalid = 1'b0;
  endtask
  task automatic idle(input int k);
    repeat (k) tick();
  endtask
  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    s_wb_adr_i = a; s_wb_dat_i = d; s_wb_sel_i = '1; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    tick();
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
  endtask
  task automatic chk_reg(input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    s_wb_adr_i = a; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
    #1;
    d = s_wb_dat_o;
    chk("wb_ack", 32'(s_wb_ack_o), 32'd1);
    chk($sformatf("reg_%02h", a), d, exp);
    s_wb_stb_i = 1'b0;
    tick();
  endtask
  task automatic chk_regs();
    chk_reg(8'h00, 32'h4D53_0001);
    chk_reg(8'h01, 32'(men));
    chk_reg(8'h02, 32'(mth));
    chk_reg(8'h03, 32'(exp_fc));
    chk_reg(8'h04, 32'(exp_num));
    chk_reg(8'h05, 32'(exp_max));
    chk_reg(8'h06, 32'(exp_total));
    chk_reg(8'h07, 32'(exp_drop));
    chk_reg(8'h08, 32'd0);
    chk_reg(8'h1B, 32'd0);
    for (int i = 0; i < N; i++) chk_reg(8'(16 + i), 32'(msnap[i]));
    chk("irq_count", 32'(irq_seen), 32'(exp_fc));
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge aclk);
    chk("rst_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("rst_irq", 32'(out_irq), 32'd0);
    chk("rst_tready", 32'(s_axi4s_tready), 32'd1);
    aresetn = 1'b1;
    chk_regs();
    // frame 1: 5 hits of class 3, 2 of class 7
    send(1, 0, 3, 5, 1); send(0, 0, 3, 5, 1); send(0, 0, 3, 5, 1); send(0, 1, 3, 5, 1);
    send(0, 0, 3, 5, 1); send(0, 0, 7, 5, 1); send(0, 0, 7, 5, 1); send(0, 1, 0, 5, 0);
    send(1, 0, 0, 5, 0);
    idle(20);
    chk_regs();
    // tie between classes 2 and 9
    for (int i = 0; i < 8; i++) send(0, i % 4 == 3, (i % 2) ? 9 : 2, 6, 1);
    send(1, 0, 0, 5, 0);
    idle(20);
    chk_regs();
    // filtering with threshold 3
    wb_write(8'h02, 32'd3); mth = 3;
    send(0, 0, 1, 2, 1); send(0, 0, 1, 5, 0); send(0, 0, 12, 5, 1); send(0, 0, 11, 3, 1);
    send(1, 0, 0, 5, 0);
    idle(20);
    chk_regs();
    // disabled accumulation
    wb_write(8'h01, 32'd0); men = 0;
    send(0, 0, 4, 9, 1); send(0, 0, 4, 9, 1);
    send(1, 0, 0, 5, 0);
    idle(20);
    chk_regs();
    wb_write(8'h01, 32'd1); men = 1;
    wb_write(8'h02, 32'd1); mth = 1;
    // boundary while scanning is dropped
    send(0, 0, 5, 5, 1); send(0, 0, 5, 5, 1); send(0, 0, 5, 5, 1);
    send(1, 0, 6, 5, 1);
    idle(4);
    send(1, 0, 6, 5, 1);
    idle(20);
    chk_regs();
    chk("drop_one", 32'(exp_drop), 32'd1);
    // random backpressure stream
    wb_write(8'h02, 32'd2); mth = 2;
    bp = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send($urandom_range(0, 49) == 0, 1'($urandom), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), 1'($urandom));
    end
    bp = 0;
    send(1, 0, 0, 5, 0);
    idle(20);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk_regs();
    // reset mid-frame
    send(0, 0, 4, 5, 1); send(0, 0, 4, 5, 1); send(0, 0, 4, 5, 1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("mid_rst_m_tnumber", 32'(m_axi4s_tnumber), 32'd0);
    chk("mid_rst_irq", 32'(out_irq), 32'd0);
    model_reset();
    q.delete();
    chk_regs();
    aresetn = 1'b1;
    send(1, 0, 4, 5, 1); send(0, 0, 4, 5, 1); send(0, 0, 8, 5, 1);
    idle(20);
    chk("no_irq_after_rearm", 32'(irq_seen), 32'd0);
    send(1, 0, 0, 5, 0);
    idle(20);
    chk_regs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
